// File: rtl/layer_draw_sequencer.sv
// Frame-draw sequencer: on every back-buffer swap, runs the enabled layer drawers in index
// order and forwards the active drawer's pixel writes to the framebuffer port.
module layer_draw_sequencer #(
  parameter int NUM_LAYERS        = 4,
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int TIMEOUT_CYCLES    = 65536,
  parameter int FRAME_CNT_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      buffer_select,
  input  logic [NUM_LAYERS-1:0]                     layer_enable,
  output logic [NUM_LAYERS-1:0]                     layer_start,
  input  logic [NUM_LAYERS-1:0]                     layer_done,
  input  logic [NUM_LAYERS-1:0]                     layer_write_en,
  input  logic [NUM_LAYERS*BUFFER_ADDR_WIDTH-1:0]   layer_write_addr,
  input  logic [NUM_LAYERS*BUFFER_DATA_WIDTH-1:0]   layer_write_data,
  output logic                                      write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0]              write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0]              write_data,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]                frame_count,
  output logic                                      overrun,
  output logic [NUM_LAYERS-1:0]                     timeout
);
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam int DW = BUFFER_DATA_WIDTH;
  localparam int IW = $clog2(NUM_LAYERS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SELECT, RUN, DONE} state_t;
  state_t state, state_n;

  logic                  s1, s2, d;
  logic [1:0]            mask_cnt;
  logic                  start;
  logic                  pending;
  logic [NUM_LAYERS-1:0] en_q;
  logic [IW-1:0]         idx, sel_idx;
  logic                  sel_found;
  logic [WW-1:0]         wd;
  logic                  wd_exp;
  logic                  act_done, act_wen;
  logic [AW-1:0]         act_addr;
  logic [DW-1:0]         act_data;
  logic [NUM_LAYERS-1:0] act_onehot;

  assign start  = (s2 != d) && (mask_cnt == 2'd0);
  assign wd_exp = (wd == WW'(TIMEOUT_CYCLES - 1));

  // Edge detect stays masked while the freshly reset sync chain fills with the live input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      d        <= 1'b0;
      mask_cnt <= 2'd3;
    end else begin
      s1 <= buffer_select;
      s2 <= s1;
      d  <= s2;
      if (mask_cnt != 2'd0) mask_cnt <= mask_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!sel_found && en_q[i] && (i >= 32'(idx))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    act_onehot = '0;
    act_done   = 1'b0;
    act_wen    = 1'b0;
    act_addr   = '0;
    act_data   = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (32'(idx) == i) begin
        act_onehot[i] = 1'b1;
        act_done      = layer_done[i];
        act_wen       = layer_write_en[i];
        act_addr      = layer_write_addr[i*AW +: AW];
        act_data      = layer_write_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start || pending) state_n = SELECT;
      SELECT:  state_n = sel_found ? RUN : DONE;
      RUN:     if (act_done || wd_exp) state_n = SELECT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      en_q        <= '0;
      idx         <= '0;
      wd          <= '0;
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      frame_count <= '0;
      timeout     <= '0;
    end else begin
      write_en <= 1'b0;
      timeout  <= '0;
      if (start && (state != IDLE)) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start || pending) begin
            en_q    <= layer_enable;
            idx     <= '0;
            pending <= 1'b0;
          end
        end
        SELECT: begin
          if (sel_found) begin
            idx <= sel_idx;
            wd  <= '0;
          end
        end
        RUN: begin
          wd         <= wd + WW'(1);
          write_en   <= act_wen;
          write_addr <= act_addr;
          write_data <= act_data;
          if (act_done || wd_exp) idx <= idx + IW'(1);
          if (!act_done && wd_exp) timeout <= act_onehot;
        end
        DONE: frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_LAYERS; i++)
      layer_start[i] = (state == RUN) && (32'(idx) == i);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    overrun    = start && (state != IDLE);
  end
endmodule

// File: tb/tb_layer_draw_sequencer.sv
// Bench for layer_draw_sequencer: emulated layer drawers, table-driven and random frames
// checked against a frame-level model, plus hand sequences for overrun and reset.
module tb_layer_draw_sequencer;
  localparam int NL = 3;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int T  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              buffer_select = 1'b0;
  logic [NL-1:0]     layer_enable = '0;
  logic [NL-1:0]     layer_start;
  logic [NL-1:0]     layer_done = '0;
  logic [NL-1:0]     layer_write_en = '0;
  logic [NL*AW-1:0]  layer_write_addr = '0;
  logic [NL*DW-1:0]  layer_write_data = '0;
  logic              write_en;
  logic [AW-1:0]     write_addr;
  logic [DW-1:0]     write_data;
  logic              busy, frame_done, overrun;
  logic [1:0]        frame_count;
  logic [NL-1:0]     timeout;

  layer_draw_sequencer #(
    .NUM_LAYERS(NL), .BUFFER_WIDTH(160), .BUFFER_HEIGHT(120), .BUFFER_DATA_WIDTH(DW),
    .BUFFER_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T), .FRAME_CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .buffer_select(buffer_select), .layer_enable(layer_enable),
    .layer_start(layer_start), .layer_done(layer_done), .layer_write_en(layer_write_en),
    .layer_write_addr(layer_write_addr), .layer_write_data(layer_write_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drawer emulation: a layer's writes are a pure function of (frame seed, layer, active cycle).
  int          dur[NL];
  int          c[NL];
  int unsigned seed = 0;
  bit          ovr = 1'b0;
  logic [27:0] eng_w;
  int          drv_cyc[$];

  function automatic logic [27:0] wr(input int unsigned s, input int i, input int k);
    int unsigned h;
    if (ovr && i == 2 && k == 2) return {1'b1, 15'd5, 12'hF00};
    h = (s * 32'd2654435761) ^ (32'(i) * 32'd40503 + 32'(k) * 32'd977);
    return {((h >> 3) % 3) != 0, 15'((h >> 5) % 19200), 12'(h >> 13)};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (layer_start[i]) begin
        c[i]++;
        eng_w = wr(seed, i, c[i]);
        layer_done[i] = (c[i] == dur[i]);
        layer_write_en[i] = eng_w[27];
        layer_write_addr[i*AW +: AW] = eng_w[26:12];
        layer_write_data[i*DW +: DW] = eng_w[11:0];
        if (eng_w[27]) drv_cyc.push_back(cyc);
      end else begin
        c[i] = 0;
        layer_done[i] = 1'($urandom);
        layer_write_en[i] = 1'($urandom);
        layer_write_addr[i*AW +: AW] = AW'($urandom);
        layer_write_data[i*DW +: DW] = DW'($urandom);
      end
    end
  end

  // Monitor: only appends/increments; tests snapshot bases and compare deltas.
  logic [26:0]   got_w[$];
  int            out_cyc[$], started[$], to_delta[$];
  int            nfd = 0, nov = 0, nbusy = 0;
  int            nto_l[NL];
  int            rise_cyc[NL];
  logic [NL-1:0] prev_ls = '0;

  always @(negedge clk) begin
    if (rst) prev_ls = '0;
    else begin
      if (write_en) begin
        got_w.push_back({write_addr, write_data});
        out_cyc.push_back(cyc);
      end
      if (frame_done) nfd++;
      if (overrun) nov++;
      if (busy) nbusy++;
      for (int i = 0; i < NL; i++) begin
        if (layer_start[i] && !prev_ls[i]) begin
          started.push_back(i);
          rise_cyc[i] = cyc;
        end
        if (timeout[i]) begin
          nto_l[i]++;
          to_delta.push_back(cyc - rise_cyc[i]);
        end
      end
      prev_ls = layer_start;
    end
  end

  int b_nfd, b_nov, b_busy, b_st, b_got, b_drv, b_out, b_td;
  int b_nto[NL];
  task automatic snap();
    b_nfd = nfd; b_nov = nov; b_busy = nbusy; b_st = started.size();
    b_got = got_w.size(); b_drv = drv_cyc.size(); b_out = out_cyc.size(); b_td = to_delta.size();
    for (int i = 0; i < NL; i++) b_nto[i] = nto_l[i];
  endtask

  // Frame-level model: enabled layers in index order, each active min(dur,T) cycles.
  logic [26:0] exp_w[$];
  int          exp_order[$];
  task automatic model_frame(input logic [NL-1:0] en);
    logic [27:0] w;
    int n;
    for (int i = 0; i < NL; i++) begin
      if (en[i]) begin
        exp_order.push_back(i);
        n = (dur[i] < T) ? dur[i] : T;
        for (int k = 1; k <= n; k++) begin
          w = wr(seed, i, k);
          if (w[27]) exp_w.push_back(w[26:0]);
        end
      end
    end
  endtask

  task automatic verify(input string tag, input logic [NL-1:0] exp_to, input int nframes,
                        input int exp_nov, input int exp_ns);
    int bad, n, nd, no;
    logic [NL-1:0] obs;
    chk({tag, " frame_done"}, 64'(nfd - b_nfd), 64'(nframes));
    chk({tag, " frame_count"}, 64'(frame_count), 64'(fc));
    chk({tag, " overrun"}, 64'(nov - b_nov), 64'(exp_nov));
    obs = '0; n = 0;
    for (int i = 0; i < NL; i++) begin
      if (nto_l[i] != b_nto[i]) obs[i] = 1'b1;
      n += nto_l[i] - b_nto[i];
    end
    chk({tag, " timeout_mask"}, 64'(obs), 64'(exp_to));
    chk({tag, " timeout_pulses"}, 64'(n), 64'(nframes * $countones(exp_to)));
    bad = 0;
    for (int j = b_td; j < to_delta.size(); j++) if (to_delta[j] != T) bad++;
    chk({tag, " timeout_delay_bad"}, 64'(bad), 64'(0));
    n = started.size() - b_st;
    chk({tag, " start_count"}, 64'(n), 64'(exp_ns));
    bad = 0;
    for (int j = 0; j < n && j < exp_order.size(); j++) if (started[b_st + j] != exp_order[j]) bad++;
    chk({tag, " start_order_bad"}, 64'(bad), 64'(0));
    n = got_w.size() - b_got;
    chk({tag, " write_count"}, 64'(n), 64'(exp_w.size()));
    bad = 0;
    for (int j = 0; j < n && j < exp_w.size(); j++) if (got_w[b_got + j] !== exp_w[j]) bad++;
    chk({tag, " write_content_bad"}, 64'(bad), 64'(0));
    nd = drv_cyc.size() - b_drv; no = out_cyc.size() - b_out;
    bad = (nd != no) ? 1 : 0;
    for (int j = 0; j < nd && j < no; j++) if (out_cyc[b_out + j] - drv_cyc[b_drv + j] != 1) bad++;
    chk({tag, " write_latency_bad"}, 64'(bad), 64'(0));
  endtask

  task automatic wait_frame_done(input string tag);
    int k = 0;
    while (!frame_done && k < 300) begin @(posedge clk); #1; k++; end
    chk({tag, " frame_done_seen"}, 64'(frame_done), 64'(1));
  endtask

  task automatic run_frame(input string tag, input logic [NL-1:0] en, input int d0, input int d1,
                           input int d2, input logic [NL-1:0] exp_to, input int exp_ns);
    int k = 0, tbz = 0, tl = 0, nb;
    bit seen = 1'b0;
    dur[0] = d0; dur[1] = d1; dur[2] = d2; seed = $urandom;
    snap();
    exp_w.delete(); exp_order.delete();
    model_frame(en);
    layer_enable = en;
    @(negedge clk) buffer_select = ~buffer_select;
    while (!seen && k < 300) begin
      @(posedge clk); #1; k++;
      if (busy && tbz == 0) tbz = k;
      if (layer_start != '0 && tl == 0) tl = k;
      if (frame_done) seen = 1'b1;
      if (k == 6) layer_enable = NL'($urandom);
    end
    chk({tag, " frame_done_seen"}, 64'(seen), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    fc = (fc + 1) % 4;
    chk({tag, " busy_latency"}, 64'(tbz), 64'(3));
    if (en != '0) chk({tag, " start_latency"}, 64'(tl), 64'(4));
    else begin
      nb = nbusy - b_busy;
      chk({tag, " busy_window_ok"}, 64'(nb >= 1 && nb <= 3), 64'(1));
    end
    verify(tag, exp_to, 1, 0, exp_ns);
  endtask

  typedef struct {
    logic [NL-1:0] en;
    int            d0, d1, d2;
    logic [NL-1:0] exp_to;
    int            exp_ns;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int k, nb0, gsz;
    logic [NL-1:0] en, eto;
    int dd[NL];

    tbl[0] = '{en: 3'b111, d0: 10, d1: 10, d2: 10, exp_to: 3'b000, exp_ns: 3};
    tbl[1] = '{en: 3'b101, d0: 5,  d1: 3,  d2: 7,  exp_to: 3'b000, exp_ns: 2};
    tbl[2] = '{en: 3'b001, d0: 20, d1: 2,  d2: 2,  exp_to: 3'b001, exp_ns: 1};
    tbl[3] = '{en: 3'b110, d0: 1,  d1: 16, d2: 17, exp_to: 3'b100, exp_ns: 2};
    tbl[4] = '{en: 3'b000, d0: 4,  d1: 4,  d2: 4,  exp_to: 3'b000, exp_ns: 0};
    tbl[5] = '{en: 3'b010, d0: 9,  d1: 1,  d2: 9,  exp_to: 3'b000, exp_ns: 1};
    tbl[6] = '{en: 3'b111, d0: 99, d1: 15, d2: 99, exp_to: 3'b101, exp_ns: 3};

    // Reset with buffer_select held high: outputs zero, no frame after release.
    rst = 1'b1; buffer_select = 1'b1; layer_enable = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({layer_start, write_en, write_addr, write_data, busy, frame_done,
                             frame_count, overrun, timeout}), 64'(0));
    @(negedge clk) rst = 1'b0;
    nb0 = nbusy;
    repeat (12) @(posedge clk);
    #1;
    chk("no_start_after_reset", 64'(nbusy - nb0), 64'(0));
    fc = 0;

    // Layer 1 disabled; layer 2's write to addr 5 must appear exactly one cycle later.
    ovr = 1'b1;
    dur[0] = 3; dur[1] = 5; dur[2] = 4; seed = $urandom;
    snap(); exp_w.delete(); exp_order.delete(); model_frame(3'b101);
    layer_enable = 3'b101;
    @(negedge clk) buffer_select = ~buffer_select;
    k = 0;
    while (!layer_start[2] && k < 100) begin @(posedge clk); #1; k++; end
    chk("t2 layer2_started", 64'(layer_start[2]), 64'(1));
    @(posedge clk); @(posedge clk); #1;
    chk("t2 write_en", 64'(write_en), 64'(1));
    chk("t2 write_addr", 64'(write_addr), 64'(5));
    chk("t2 write_data", 64'(write_data), 64'(12'hF00));
    wait_frame_done("t2");
    repeat (3) @(posedge clk);
    #1;
    fc = (fc + 1) % 4;
    verify("t2", 3'b000, 1, 0, 2);
    ovr = 1'b0;

    // Two extra toggles mid-frame: two overrun pulses, exactly one queued frame.
    dur[0] = 10; dur[1] = 10; dur[2] = 10; seed = $urandom;
    snap(); exp_w.delete(); exp_order.delete();
    model_frame(3'b111); model_frame(3'b111);
    layer_enable = 3'b111;
    @(negedge clk) buffer_select = ~buffer_select;
    repeat (8) @(negedge clk);
    buffer_select = ~buffer_select;
    repeat (6) @(negedge clk);
    buffer_select = ~buffer_select;
    wait_frame_done("ovr first");
    k = 0;
    while (layer_start == '0 && k < 20) begin @(posedge clk); #1; k++; end
    chk("ovr pending_restart_gap", 64'(k), 64'(3));
    wait_frame_done("ovr second");
    repeat (6) @(posedge clk);
    #1;
    fc = (fc + 2) % 4;
    verify("ovr", 3'b000, 2, 2, 6);

    // Reset in the middle of RUN.
    dur[0] = 10; dur[1] = 10; dur[2] = 10;
    layer_enable = 3'b111;
    @(negedge clk) buffer_select = ~buffer_select;
    k = 0;
    while (!layer_start[1] && k < 100) begin @(posedge clk); #1; k++; end
    chk("rst_mid layer1_running", 64'(layer_start[1]), 64'(1));
    @(negedge clk) begin rst = 1'b1; buffer_select = 1'b1; end
    @(posedge clk); #1;
    chk("rst_mid outputs", 64'({layer_start, write_en, write_addr, write_data, busy, frame_done,
                               frame_count, overrun, timeout}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    nb0 = nbusy; gsz = got_w.size();
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid no_restart", 64'(nbusy - nb0), 64'(0));
    chk("rst_mid no_writes", 64'(got_w.size() - gsz), 64'(0));
    chk("rst_mid frame_count", 64'(frame_count), 64'(0));
    fc = 0;

    for (int v = 0; v < 7; v++)
      run_frame($sformatf("tbl%0d", v), tbl[v].en, tbl[v].d0, tbl[v].d1, tbl[v].d2,
                tbl[v].exp_to, tbl[v].exp_ns);

    for (int r = 0; r < 12; r++) begin
      en = NL'($urandom);
      eto = '0;
      for (int i = 0; i < NL; i++) begin
        dd[i] = $urandom_range(1, 20);
        eto[i] = en[i] && (dd[i] > T);
      end
      run_frame($sformatf("rnd%0d", r), en, dd[0], dd[1], dd[2], eto, $countones(en));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end
endmodule
